ps2_move_decoder: RTL and testbench

Receives PS/2 keyboard frames, decodes scan-code set 2, and turns arrow presses into move requests for `game2048`. Also produces one-cycle `start` and `reset` pulses from the S and R keys. It sits directly upstream of `game2048`:
- `direction` feeds its direction input.
- `start_pulse` / `reset_pulse` feed its start/reset.

---
 rtl/ps2_move_decoder.sv | 255 +++++++++++++++++++++++++
 tb/tb_ps2_move_decoder.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: PS/2 scan-code set 2 receiver and decoder. Arrow keys become
// one-hot move requests held in a one-entry buffer with a valid/ready handshake;
// S and R make codes become one-cycle start/reset pulses.
// Optional feature macro: PS2_TYPEMATIC_EN. When defined, every arrow make code
// (including keyboard auto-repeat) produces a move. When undefined, a held-key
// bit per arrow suppresses repeats until the matching E0 F0 break arrives.
module ps2_move_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [3:0] direction,
    output logic       start_pulse,
    output logic       reset_pulse,
    output logic       frame_error,
    output logic       move_dropped
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXTBRK} dec_state_t;

    // Synchroniser and edge detector
    logic r_clk_s1, r_clk_s2, r_clk_hist;
    logic r_dat_s1, r_dat_s2;
    logic w_fall;

    // Receiver
    rx_state_t       r_rx_state, w_rx_next;
    logic [7:0]      r_shift;
    logic [2:0]      r_bit_cnt;
    logic            r_parity_ok;
    logic [TO_W-1:0] r_to_cnt;
    logic            w_timeout;
    logic            w_byte_good;
    logic            w_frame_bad;
    logic            r_byte_ready;
    logic            r_frame_error;

    // Decoder
    dec_state_t r_dec_state, w_dec_next;
    logic [3:0] w_key_dir;
    logic       w_arrow_make;
    logic       w_arrow_break;
    logic       w_start;
    logic       w_reset;
    logic       w_new_move;
    logic       w_accept;

    // Output registers
    logic       r_move_valid;
    logic [3:0] r_direction;
    logic       r_start_pulse;
    logic       r_reset_pulse;
    logic       r_move_dropped;

    // Bring the keyboard lines into the system clock domain; idle lines are high.
    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours; blocking here would collapse the two-flop chain.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_hist <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= PS2_CLK;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_dat_s1   <= PS2_DAT;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall    = r_clk_hist & ~r_clk_s2;
    assign w_timeout = (r_rx_state != RX_IDLE) && !w_fall && (r_to_cnt == TO_LAST);

    // Receiver state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) r_rx_state <= RX_IDLE;
        else          r_rx_state <= w_rx_next;
    end

    // Receiver next state; stop-bit edge qualifies the byte or flags a bad frame.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rx_next   = r_rx_state;
        w_byte_good = 1'b0;
        w_frame_bad = 1'b0;
        if (w_timeout) begin
            w_rx_next   = RX_IDLE;
            w_frame_bad = 1'b1;
        end else if (w_fall) begin
            case (r_rx_state)
                RX_IDLE:   if (!r_dat_s2) w_rx_next = RX_DATA;
                RX_DATA:   if (r_bit_cnt == 3'd7) w_rx_next = RX_PARITY;
                RX_PARITY: w_rx_next = RX_STOP;
                RX_STOP: begin
                    w_rx_next = RX_IDLE;
                    if (r_dat_s2 && r_parity_ok) w_byte_good = 1'b1;
                    else                         w_frame_bad = 1'b1;
                end
                default:   w_rx_next = RX_IDLE;
            endcase
        end
    end

    // Receiver datapath: shift LSB first, check odd parity, run the frame timeout.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_shift       <= 8'd0;
            r_bit_cnt     <= 3'd0;
            r_parity_ok   <= 1'b0;
            r_to_cnt      <= '0;
            r_byte_ready  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            if (w_fall) begin
                case (r_rx_state)
                    RX_IDLE:   r_bit_cnt <= 3'd0;
                    RX_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    RX_PARITY: r_parity_ok <= ^{r_shift, r_dat_s2};
                    default:   ;
                endcase
            end
            if (r_rx_state == RX_IDLE || w_fall) r_to_cnt <= '0;
            else                                 r_to_cnt <= r_to_cnt + 1'b1;
            r_byte_ready  <= w_byte_good;
            r_frame_error <= w_frame_bad;
        end
    end

    // Map an extended scan code to its one-hot direction (0 for non-arrows).
    always_comb begin
        w_key_dir = 4'b0000;
        case (r_shift)
            SC_UP:    w_key_dir = 4'b1000;
            SC_DOWN:  w_key_dir = 4'b0100;
            SC_LEFT:  w_key_dir = 4'b0010;
            SC_RIGHT: w_key_dir = 4'b0001;
            default:  w_key_dir = 4'b0000;
        endcase
    end

    // Decoder state register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) r_dec_state <= D_IDLE;
        else          r_dec_state <= w_dec_next;
    end

    // Decoder next state and per-byte actions; a frame error abandons any prefix.
    always_comb begin
        w_dec_next    = r_dec_state;
        w_arrow_make  = 1'b0;
        w_arrow_break = 1'b0;
        w_start       = 1'b0;
        w_reset       = 1'b0;
        if (r_frame_error) begin
            w_dec_next = D_IDLE;
        end else if (r_byte_ready) begin
            case (r_dec_state)
                D_IDLE: begin
                    if (r_shift == SC_EXT)      w_dec_next = D_EXT;
                    else if (r_shift == SC_BRK) w_dec_next = D_BRK;
                    else begin
                        w_start = (r_shift == SC_S);
                        w_reset = (r_shift == SC_R);
                    end
                end
                D_EXT: begin
                    if (r_shift == SC_BRK) w_dec_next = D_EXTBRK;
                    else begin
                        w_dec_next   = D_IDLE;
                        w_arrow_make = |w_key_dir;
                    end
                end
                D_EXTBRK: begin
                    w_dec_next    = D_IDLE;
                    w_arrow_break = |w_key_dir;
                end
                default:  w_dec_next = D_IDLE;
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_EN
    assign w_new_move = w_arrow_make;
`else
    logic [3:0] r_held;

    // Held-key bits: set on make, cleared on the matching extended break.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)           r_held <= 4'b0000;
        else if (w_arrow_make)  r_held <= r_held | w_key_dir;
        else if (w_arrow_break) r_held <= r_held & ~w_key_dir;
    end

    assign w_new_move = w_arrow_make && ((r_held & w_key_dir) == 4'b0000);
`endif

    assign w_accept = r_move_valid && move_ready;

    // One-entry move buffer plus key pulses; a new move may replace one leaving this cycle.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_move_valid   <= 1'b0;
            r_direction    <= 4'b0000;
            r_start_pulse  <= 1'b0;
            r_reset_pulse  <= 1'b0;
            r_move_dropped <= 1'b0;
        end else begin
            r_start_pulse <= w_start;
            r_reset_pulse <= w_reset;
            if (w_new_move) begin
                if (!r_move_valid || w_accept) begin
                    r_move_valid <= 1'b1;
                    r_direction  <= w_key_dir;
                end else begin
                    r_move_dropped <= 1'b1;
                end
            end else if (w_accept) begin
                r_move_valid <= 1'b0;
                r_direction  <= 4'b0000;
            end
        end
    end

    assign move_valid   = r_move_valid;
    assign direction    = r_direction;
    assign start_pulse  = r_start_pulse;
    assign reset_pulse  = r_reset_pulse;
    assign frame_error  = r_frame_error;
    assign move_dropped = r_move_dropped;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb_ps2_move_decoder: directed timing checks followed by randomized key events
// compared against a key-level model of the arrow/S/R behaviour.
module tb_ps2_move_decoder;

    localparam int TO   = 50000;
    localparam int HALF = 6;
    localparam int GAP  = 16;
`ifdef PS2_TYPEMATIC_EN
    localparam bit TYPEMATIC = 1'b1;
`else
    localparam bit TYPEMATIC = 1'b0;
`endif

    logic       CLOCK_50;
    logic       reset_n;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       move_ready;
    logic       move_valid;
    logic [3:0] direction;
    logic       start_pulse;
    logic       reset_pulse;
    logic       frame_error;
    logic       move_dropped;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters sampled on every rising edge.
    int         mon_moves = 0;
    int         mon_start = 0;
    int         mon_reset = 0;
    int         mon_fe    = 0;
    int         mon_inv   = 0;
    logic [3:0] mon_last  = 4'b0000;

    ps2_move_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .PS2_CLK     (PS2_CLK),
        .PS2_DAT     (PS2_DAT),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .direction   (direction),
        .start_pulse (start_pulse),
        .reset_pulse (reset_pulse),
        .frame_error (frame_error),
        .move_dropped(move_dropped)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (move_valid && move_ready) begin
            mon_moves <= mon_moves + 1;
            mon_last  <= direction;
        end
        if (start_pulse) mon_start <= mon_start + 1;
        if (reset_pulse) mon_reset <= mon_reset + 1;
        if (frame_error) mon_fe    <= mon_fe + 1;
        if ((!move_valid && direction != 4'b0000) || (move_valid && !$onehot(direction)))
            mon_inv <= mon_inv + 1;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    // Present one bit and drop the keyboard clock (left low on return).
    task automatic ps2_setup(input logic b);
        PS2_DAT = b;
        wait_neg(HALF);
        PS2_CLK = 1'b0;
    endtask

    task automatic ps2_release();
        wait_neg(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_setup(b);
        ps2_release();
    endtask

    // Whole frame up to the stop-bit falling edge; the caller observes timing then releases.
    task automatic send_frame_hold(input logic [7:0] b, input bit bad_par);
        logic par;
        par = bad_par ? (^b) : ~(^b);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_setup(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_frame_hold(b, 1'b0);
        ps2_release();
        wait_neg(GAP);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   32'(move_valid),   32'd0);
        check({tag, "_dir"},     32'(direction),    32'd0);
        check({tag, "_start"},   32'(start_pulse),  32'd0);
        check({tag, "_reset"},   32'(reset_pulse),  32'd0);
        check({tag, "_ferr"},    32'(frame_error),  32'd0);
        check({tag, "_dropped"}, 32'(move_dropped), 32'd0);
    endtask

    logic [7:0] arrow_code [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] other_code [4] = '{8'h1C, 8'h15, 8'h29, 8'h5A};

    // Key-level reference state for the random phase.
    bit         m_held [4];
    int         m_moves, m_start, m_reset;
    logic [3:0] m_last;
    int         base_moves, base_start, base_reset, base_fe;
    int         kind, k;
    bit         stable;

    initial begin
        reset_n    = 1'b0;
        PS2_CLK    = 1'b1;
        PS2_DAT    = 1'b1;
        move_ready = 1'b1;

        // Reset state
        wait_neg(3);
        check_all_zero("reset");
        reset_n = 1'b1;
        wait_neg(4);
        check_all_zero("post_reset");

        // Up arrow: one-cycle move at t+2
        send_frame(8'hE0);
        send_frame_hold(8'h75, 1'b0);
        wait_neg(3);
        check("up_t1_valid", 32'(move_valid), 32'd0);
        wait_neg(1);
        check("up_t2_valid", 32'(move_valid), 32'd1);
        check("up_t2_dir",   32'(direction),  32'h8);
        wait_neg(1);
        check("up_t3_valid", 32'(move_valid), 32'd0);
        check("up_t3_dir",   32'(direction),  32'd0);
        ps2_release();
        wait_neg(GAP);

        // Left arrow with consumer stalled
        move_ready = 1'b0;
        send_frame(8'hE0);
        send_frame_hold(8'h6B, 1'b0);
        wait_neg(4);
        check("left_t2_valid", 32'(move_valid), 32'd1);
        check("left_t2_dir",   32'(direction),  32'h2);
        ps2_release();
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK_50);
            if (direction !== 4'b0010 || move_valid !== 1'b1) stable = 1'b0;
        end
        check("left_stall_hold", 32'(stable), 32'd1);

        // Right arrow while the left move is pending
        send_frame(8'hE0);
        send_frame(8'h74);
        check("drop_flag",  32'(move_dropped), 32'd1);
        check("drop_dir",   32'(direction),    32'h2);
        check("drop_valid", 32'(move_valid),   32'd1);
        move_ready = 1'b1;
        wait_neg(1);
        check("stall_release_valid", 32'(move_valid), 32'd0);
        check("stall_release_dir",   32'(direction),  32'd0);

        // Release every arrow pressed so far
        for (int i = 0; i < 4; i++) begin
            send_frame(8'hE0);
            send_frame(8'hF0);
            send_frame(arrow_code[i]);
        end

        // Parity error on S, then a clean S
        send_frame_hold(8'h1B, 1'b1);
        wait_neg(3);
        check("parity_ferr_t1", 32'(frame_error), 32'd1);
        wait_neg(1);
        check("parity_start_t2", 32'(start_pulse), 32'd0);
        check("parity_ferr_t2",  32'(frame_error), 32'd0);
        ps2_release();
        wait_neg(GAP);
        send_frame_hold(8'h1B, 1'b0);
        wait_neg(3);
        check("s_ferr_t1", 32'(frame_error), 32'd0);
        wait_neg(1);
        check("s_start_t2", 32'(start_pulse), 32'd1);
        wait_neg(1);
        check("s_start_t3", 32'(start_pulse), 32'd0);
        ps2_release();
        wait_neg(GAP);

        // Timeout: start bit plus 4 data bits, then silence
        base_fe    = mon_fe;
        base_reset = mon_reset;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        wait_neg(TO + 40);
        check("timeout_ferr_count", 32'(mon_fe - base_fe),       32'd1);
        check("timeout_no_reset",   32'(mon_reset - base_reset), 32'd0);
        send_frame_hold(8'h2D, 1'b0);
        wait_neg(4);
        check("after_timeout_reset_pulse", 32'(reset_pulse), 32'd1);
        ps2_release();
        wait_neg(GAP);

        // Auto-repeat of the down arrow
        base_moves = mon_moves;
        for (int i = 0; i < 3; i++) begin
            send_frame(8'hE0);
            send_frame(8'h72);
        end
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h72);
        send_frame(8'hE0);
        send_frame(8'h72);
        check("repeat_moves", 32'(mon_moves - base_moves), TYPEMATIC ? 32'd4 : 32'd2);
        check("repeat_dir",   32'(mon_last),               32'h4);

        // Mid-frame reset with a move pending and the dropped flag set
        move_ready = 1'b0;
        send_frame(8'hE0);
        send_frame(8'h6B);
        check("pre_reset_valid", 32'(move_valid), 32'd1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_setup(1'b0);
        wait_neg(3);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        wait_neg(3);
        reset_n    = 1'b1;
        move_ready = 1'b1;
        wait_neg(4);
        base_moves = mon_moves;
        send_frame(8'hE0);
        send_frame(8'h6B);
        check("held_cleared_move", 32'(mon_moves - base_moves), 32'd1);
        check("held_cleared_dir",  32'(mon_last),               32'h2);
        send_frame(8'hE0);
        send_frame(8'hF0);
        send_frame(8'h6B);

        // Randomized key events against the key-level model
        for (int i = 0; i < 4; i++) m_held[i] = 1'b0;
        m_moves = 0; m_start = 0; m_reset = 0; m_last = 4'b0010;
        base_moves = mon_moves;
        base_start = mon_start;
        base_reset = mon_reset;
        base_fe    = mon_fe;
        for (int e = 0; e < 30; e++) begin
            kind = int'($urandom_range(0, 7));
            k    = int'($urandom_range(0, 3));
            case (kind)
                0, 1, 2, 3: begin
                    send_frame(8'hE0);
                    send_frame(arrow_code[k]);
                    if (TYPEMATIC || !m_held[k]) begin
                        m_moves++;
                        m_last = 4'b1000 >> k;
                    end
                    m_held[k] = 1'b1;
                end
                4: begin
                    send_frame(8'hE0);
                    send_frame(8'hF0);
                    send_frame(arrow_code[k]);
                    m_held[k] = 1'b0;
                end
                5: begin
                    if (k[0]) begin send_frame(8'h2D); m_reset++; end
                    else      begin send_frame(8'h1B); m_start++; end
                end
                6: begin
                    if (k[0]) begin send_frame(8'hE0); send_frame(8'h1B); end
                    else      begin send_frame(8'hF0); send_frame(8'h2D); end
                end
                default: begin
                    if (k[1]) send_frame(8'hF0);
                    send_frame(other_code[k]);
                end
            endcase
            check("rand_moves", 32'(mon_moves - base_moves), 32'(m_moves));
            check("rand_dir",   32'(mon_last),               32'(m_last));
            check("rand_start", 32'(mon_start - base_start), 32'(m_start));
            check("rand_reset", 32'(mon_reset - base_reset), 32'(m_reset));
        end
        check("rand_no_ferr",    32'(mon_fe - base_fe), 32'd0);
        check("rand_no_dropped", 32'(move_dropped),     32'd0);
        check("dir_invariant",   32'(mon_inv),          32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
